// File: rtl/alu_pkg.sv
// Shared op codes, ALUOp/funct encodings and FSM states for the ALU execute stage.
package alu_pkg;

    localparam int OPW = 4;

    localparam logic [OPW-1:0] ALU_NONE = 4'd0;
    localparam logic [OPW-1:0] ALU_AND  = 4'd1;
    localparam logic [OPW-1:0] ALU_XOR  = 4'd2;
    localparam logic [OPW-1:0] ALU_SLL  = 4'd3;
    localparam logic [OPW-1:0] ALU_ADD  = 4'd4;
    localparam logic [OPW-1:0] ALU_SUB  = 4'd5;
    localparam logic [OPW-1:0] ALU_MUL  = 4'd6;
    localparam logic [OPW-1:0] ALU_SRAI = 4'd7;
    localparam logic [OPW-1:0] ALU_OR   = 4'd8;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [9:0] F10_AND = 10'b0000000111;
    localparam logic [9:0] F10_XOR = 10'b0000000100;
    localparam logic [9:0] F10_SLL = 10'b0000000001;
    localparam logic [9:0] F10_ADD = 10'b0000000000;
    localparam logic [9:0] F10_SUB = 10'b0100000000;
    localparam logic [9:0] F10_MUL = 10'b0000001000;
    localparam logic [9:0] F10_OR  = 10'b0000000110;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_SRAI = 3'b101;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct decoder producing the internal op code and an illegal flag.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0]     ALUOp_i,
    input  logic [9:0]     funct_i,
    output logic [OPW-1:0] op_o,
    output logic           illegal_o
);

    always_comb begin
        op_o = ALU_NONE;
        case (ALUOp_i)
            ALUOP_ADD: op_o = ALU_ADD;
            ALUOP_SUB: op_o = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct_i)
                    F10_AND: op_o = ALU_AND;
                    F10_XOR: op_o = ALU_XOR;
                    F10_SLL: op_o = ALU_SLL;
                    F10_ADD: op_o = ALU_ADD;
                    F10_SUB: op_o = ALU_SUB;
                    F10_MUL: op_o = ALU_MUL;
                    F10_OR:  op_o = ALU_OR;
                    default: op_o = ALU_NONE;
                endcase
            end
            default: begin
                // I-type ignores funct7 entirely.
                case (funct_i[2:0])
                    F3_ADDI: op_o = ALU_ADD;
                    F3_SRAI: op_o = ALU_SRAI;
                    default: op_o = ALU_NONE;
                endcase
            end
        endcase
        illegal_o = (op_o == ALU_NONE);
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiplier behind valid/ready.
// Optional macro MUL_EARLY_EXIT_EN ends the multiply once the remaining multiplier is zero.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      ALUOp_i,
    input  logic [9:0]      funct_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            illegal_o
);

    localparam int CW = SHW + 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q, acc_d;

    logic [OPW-1:0]  dec_op;
    logic            dec_ill;
    logic            accept;
    logic [XLEN-1:0] alu_res;

    function automatic logic [XLEN-1:0] alu_calc(input logic [OPW-1:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic [XLEN-1:0]        r;
        sa = signed'(a);
        case (op)
            ALU_AND:  r = a & b;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = a << b[SHW-1:0];
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SRAI: r = sa >>> b[SHW-1:0];
            ALU_OR:   r = a | b;
            default:  r = '0;
        endcase
        return r;
    endfunction

    alu_ctrl_decode u_dec (
        .ALUOp_i   (ALUOp_i),
        .funct_i   (funct_i),
        .op_o      (dec_op),
        .illegal_o (dec_ill)
    );

    assign ready_o = (state_q == IDLE) && (!valid_q || ready_i);
    assign accept  = valid_i && ready_o && !flush_i;
    assign alu_res = alu_calc(dec_op, op_a_i, op_b_i);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec_op == ALU_MUL) begin
                        mcand_d  = op_a_i;
                        mplier_d = op_b_i;
                        acc_d    = '0;
                        cnt_d    = CW'(XLEN);
                        state_d  = MUL;
                    end else begin
                        valid_d   = 1'b1;
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        illegal_d = dec_ill;
                    end
                end
            end
            MUL: begin
`ifdef MUL_EARLY_EXIT_EN
                if (mplier_q == '0) begin
                    state_d = DONE;
                end else
`endif
                begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Hold the product here until the output slot frees up.
                if (!valid_q || ready_i) begin
                    valid_d   = 1'b1;
                    result_d  = acc_q;
                    zero_d    = (acc_q == '0);
                    illegal_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    // Multiplier working registers carry no reset; they are loaded on every mul accept.
    always_ff @(posedge clk_i) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
    end

    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign zero_o    = zero_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against a behavioural reference model.
module tb_alu_exec_unit;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            flush_i;
    logic            valid_i;
    logic            ready_o;
    logic [1:0]      ALUOp_i;
    logic [9:0]      funct_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;
    logic            zero_o;
    logic            illegal_o;

    int errs   = 0;
    int checks = 0;

    logic [9:0] legal_f [7] = '{10'b0000000111, 10'b0000000100, 10'b0000000001,
                                10'b0000000000, 10'b0100000000, 10'b0000001000,
                                10'b0000000110};

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .flush_i   (flush_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .ALUOp_i   (ALUOp_i),
        .funct_i   (funct_i),
        .op_a_i    (op_a_i),
        .op_b_i    (op_b_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o),
        .zero_o    (zero_o),
        .illegal_o (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: what the op should produce, straight from the op table.
    task automatic ref_op(input logic [1:0] aluop, input logic [9:0] f,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          output logic [XLEN-1:0] r, output logic ill, output logic is_mul);
        int sh;
        sh     = int'(b % XLEN);
        r      = '0;
        ill    = 1'b0;
        is_mul = 1'b0;
        if (aluop == 2'd0) r = a + b;
        else if (aluop == 2'd1) r = a - b;
        else if (aluop == 2'd2) begin
            if (f == 10'b0000000111) r = a & b;
            else if (f == 10'b0000000100) r = a ^ b;
            else if (f == 10'b0000000001) r = a << sh;
            else if (f == 10'b0000000000) r = a + b;
            else if (f == 10'b0100000000) r = a - b;
            else if (f == 10'b0000000110) r = a | b;
            else if (f == 10'b0000001000) begin
                r = a * b;
                is_mul = 1'b1;
            end else ill = 1'b1;
        end else begin
            if (f[2:0] == 3'b000) r = a + b;
            else if (f[2:0] == 3'b101) r = XLEN'($signed(a) >>> sh);
            else ill = 1'b1;
        end
    endtask

    function automatic int mul_latency(input logic [XLEN-1:0] b);
        int len;
        len = 0;
        for (int i = 0; i < XLEN; i++) if (b[i]) len = i + 1;
`ifdef MUL_EARLY_EXIT_EN
        return (2 + len < XLEN + 1) ? 2 + len : XLEN + 1;
`else
        return XLEN + 1;
`endif
    endfunction

    task automatic run_op(input logic [1:0] aluop, input logic [9:0] f,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input string tag);
        logic [XLEN-1:0] r;
        logic            ill, is_mul, busy_rdy;
        int              n, lat, exp_lat;
        ref_op(aluop, f, a, b, r, ill, is_mul);
        exp_lat = is_mul ? mul_latency(b) : 0;
        @(negedge clk_i);
        valid_i = 1'b1;
        ALUOp_i = aluop;
        funct_i = f;
        op_a_i  = a;
        op_b_i  = b;
        n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "/ready"}, 64'(ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        valid_i  = 1'b0;
        lat      = 0;
        busy_rdy = 1'b0;
        while (!valid_o && lat < 200) begin
            if (ready_o) busy_rdy = 1'b1;
            @(posedge clk_i);
            #1;
            lat++;
        end
        chk({tag, "/valid"}, 64'(valid_o), 64'd1);
        chk({tag, "/result"}, 64'(result_o), 64'(r));
        chk({tag, "/zero"}, 64'(zero_o), 64'(r == '0));
        chk({tag, "/illegal"}, 64'(illegal_o), 64'(ill));
        chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        if (is_mul) chk({tag, "/busy_ready"}, 64'(busy_rdy), 64'd0);
    endtask

    initial begin
        logic [1:0]      aluop;
        logic [9:0]      f;
        logic [XLEN-1:0] a, b;
        int              sel;
        logic            saw;

        rst_n_i = 1'b0;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        ALUOp_i = '0;
        funct_i = '0;
        op_a_i  = '0;
        op_b_i  = '0;
        #12;
        chk("rst/valid", 64'(valid_o), 64'd0);
        chk("rst/result", 64'(result_o), 64'd0);
        chk("rst/zero", 64'(zero_o), 64'd0);
        chk("rst/illegal", 64'(illegal_o), 64'd0);
        chk("rst/ready", 64'(ready_o), 64'd1);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        run_op(2'b10, 10'b0100000000, 32'd5, 32'd7, "sub5m7");
        run_op(2'b11, 10'b0100000101, 32'h8000_0000, 32'd4, "srai");
        run_op(2'b10, 10'b0000000001, 32'd1, 32'd33, "sll33");
        run_op(2'b10, 10'b0000001000, 32'd3, 32'hFFFF_FFFF, "mul3");
        run_op(2'b10, 10'b0000001000, 32'd3, 32'd2, "mul_b2");
        run_op(2'b10, 10'b0000001000, 32'd1234, 32'd0, "mul_b0");
        run_op(2'b10, 10'b0000000010, 32'd9, 32'd9, "illegal");
        run_op(2'b01, 10'b1111111111, 32'd7, 32'd7, "beq_zero");

        for (int i = 0; i < 60; i++) begin
            aluop = 2'($urandom_range(0, 3));
            f     = 10'($urandom);
            sel   = $urandom_range(0, 9);
            if (aluop == 2'b10 && sel < 7) f = legal_f[sel];
            if (aluop == 2'b11 && sel < 4) f[2:0] = 3'b101;
            if (aluop == 2'b11 && sel >= 4 && sel < 7) f[2:0] = 3'b000;
            a = $urandom;
            b = $urandom;
            if (sel == 8) b = 32'($urandom_range(0, 40));
            if (sel == 9) a = 32'h8000_0000 | a;
            run_op(aluop, f, a, b, $sformatf("rnd%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            b = $urandom >> $urandom_range(0, 31);
            run_op(2'b10, 10'b0000001000, $urandom, b, $sformatf("rmul%0d", i));
        end

        // Backpressure: result held while ready_i is low, then accept on release.
        repeat (2) @(negedge clk_i);
        ready_i = 1'b0;
        run_op(2'b00, 10'd0, 32'd1, 32'd1, "bp_add");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp/valid_hold", 64'(valid_o), 64'd1);
            chk("bp/result_hold", 64'(result_o), 64'd2);
            chk("bp/ready_low", 64'(ready_o), 64'd0);
        end
        @(negedge clk_i);
        ready_i = 1'b1;
        valid_i = 1'b1;
        ALUOp_i = 2'b00;
        op_a_i  = 32'd3;
        op_b_i  = 32'd4;
        #1;
        chk("bp/ready_release", 64'(ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        chk("bp/b2b_valid", 64'(valid_o), 64'd1);
        chk("bp/b2b_result", 64'(result_o), 64'd7);

        // Flush mid-multiply.
        @(negedge clk_i);
        valid_i = 1'b1;
        ALUOp_i = 2'b10;
        funct_i = 10'b0000001000;
        op_a_i  = 32'd3;
        op_b_i  = 32'd5;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("flush/ready_idle", 64'(ready_o), 64'd1);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (valid_o) saw = 1'b1;
        end
        chk("flush/no_valid", 64'(saw), 64'd0);
        run_op(2'b00, 10'd0, 32'd2, 32'd2, "flush_add");

        // Flush blocks a same-cycle request.
        repeat (2) @(negedge clk_i);
        valid_i = 1'b1;
        flush_i = 1'b1;
        ALUOp_i = 2'b00;
        op_a_i  = 32'd9;
        op_b_i  = 32'd9;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        chk("flush/same_cycle", 64'(valid_o), 64'd0);

        // Asynchronous reset in the middle of a multiply.
        run_op(2'b00, 10'd0, 32'd5, 32'd6, "pre_rst");
        @(negedge clk_i);
        valid_i = 1'b1;
        ALUOp_i = 2'b10;
        funct_i = 10'b0000001000;
        op_a_i  = 32'd7;
        op_b_i  = 32'hFFFF;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #3;
        rst_n_i = 1'b0;
        #1;
        chk("arst/valid", 64'(valid_o), 64'd0);
        chk("arst/result", 64'(result_o), 64'd0);
        chk("arst/zero", 64'(zero_o), 64'd0);
        chk("arst/illegal", 64'(illegal_o), 64'd0);
        chk("arst/ready", 64'(ready_o), 64'd1);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        run_op(2'b00, 10'd0, 32'd2, 32'd2, "post_rst");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised execute stage: decodes ALUOp/funct into an internal op code and computes the result.
- Single-cycle ops (and/xor/sll/add/sub/or/srai) return in 1 cycle; mul runs on an iterative shift-add datapath over multiple cycles.
- Valid/ready handshakes on input and output sides; sits between ID/EX pipeline register and EX/MEM, stalling the pipeline via ready_o.

Parameters:
- XLEN, 32, operand/result width (power of 2, >=8).
- SHW, $clog2(XLEN), shift-amount bits taken from op_b_i.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous abort of in-flight op and pending result.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept request this cycle.
- ALUOp_i  in  2  00 add, 01 sub (branch compare), 10 R-type, 11 I-type.
- funct_i  in  10  {funct7, funct3}.
- op_a_i  in  XLEN  operand A.
- op_b_i  in  XLEN  operand B / immediate.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.
- result_o  out  XLEN  result.
- zero_o  out  1  result_o == 0.
- illegal_o  out  1  decode failed for this result.

Behaviour:
- Reset: state IDLE, valid_o=0, result_o=0, zero_o=0, illegal_o=0, counter=0. ready_o=1 after reset.
- Decode codes: and=1, xor=2, sll=3, add=4, sub=5, mul=6, srai=7, or=8.
- ALUOp 10 uses full funct_i: 0000000111 and, 0000000100 xor, 0000000001 sll, 0000000000 add, 0100000000 sub, 0000001000 mul, 0000000110 or.
- ALUOp 11 uses funct3 only: 000 add, 101 srai.
- ALUOp 00 is add; ALUOp 01 is sub.
- Any other combination is illegal: result 0, illegal_o=1, 1-cycle latency.
- Shifts use op_b_i[SHW-1:0]; srai is arithmetic. All arithmetic is modulo 2^XLEN; mul returns the low XLEN bits.
- Output register: valid_o holds, with result/zero/illegal stable, until valid_o && ready_i. No combinational path from valid_i to valid_o.
- ready_o = (state==IDLE) && (!valid_o || ready_i). An accept in the same cycle a result is consumed is legal (back-to-back, 1 op/cycle).
- FSM:
  - IDLE: on accept of a non-mul op, register result; valid_o=1 next cycle. On accept of mul, latch multiplicand=op_a, multiplier=op_b, acc=0, cnt=XLEN, go to MUL.
  - MUL: each cycle, if multiplier[0] then acc+=multiplicand; multiplicand<<=1, multiplier>>=1, cnt--. When cnt reaches 0, go to DONE.
  - DONE: load acc into output register when output slot is free (!valid_o || ready_i), then IDLE. Waits in DONE under backpressure.
- Mul latency: valid_o rises XLEN+1 cycles after accept edge when not backpressured. ready_o=0 throughout MUL/DONE.
- flush_i, highest priority: state to IDLE, valid_o=0, counter cleared, and a same-cycle valid_i is not accepted. ready_o is still computed from the current state.
- Async reset mid-mul: immediate return to IDLE, all outputs to reset values.
- valid_i is ignored while ready_o=0; no request buffering.

Optional Feature:
- Macro MUL_EARLY_EXIT_EN.
- Defined: in MUL, if remaining multiplier==0 at the start of a cycle, go directly to DONE. Latency = 1 + (index of highest set bit of op_b, +1) + 1; op_b=0 gives 2 cycles (MUL exits on first cycle).
- Undefined: fixed XLEN iterations regardless of operands.
- Results are identical either way.

Decomposition:
- Package alu_pkg: op-code localparams (ALU_AND..ALU_OR), ALUOp encodings, funct10/funct3 match constants, FSM state enum {IDLE, MUL, DONE}.
- One combinational sub-module, alu_ctrl_decode (ALUOp_i, funct_i -> op code, illegal flag).
- Datapath and FSM stay in alu_exec_unit.

Test Plan:
- ALUOp=10, funct=0100000000, a=5, b=7, ready_i=1 -> next cycle result=0xFFFFFFFE, zero=0, illegal=0.
- ALUOp=11, funct3=101, a=0x80000000, b=4 -> result=0xF8000000. Same cycle pair ALUOp=10 sll a=1 b=33 -> result=2 (shamt 1).
- mul a=3 b=0xFFFFFFFF, feature off -> ready_o low 33 cycles; valid_o 33 cycles after accept; result=0xFFFFFFFD. Feature on with b=2 -> latency 4, result=6.
- Backpressure: hold ready_i=0 for 5 cycles after add 1+1 -> valid_o/result=2 stable, ready_o=0. Release -> next op accepted that cycle.
- flush_i asserted mid-mul at cycle 10 -> no valid_o. IDLE next cycle; subsequent add 2+2 returns 4.
- ALUOp=10 funct=0000000010 -> illegal_o=1, result=0, zero=1. rst_n_i pulsed low mid-mul -> all outputs 0 asynchronously.
